// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-stage types: FSM states, PC step, resolved-branch record
package if_pkg;

  localparam int INSTR_BYTES   = 4;
  localparam int IF_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

  // Resolved-branch record as produced by execute.
  typedef struct packed {
    logic [IF_ADDR_WIDTH-1:0] pc;
    logic                     taken;
    logic [IF_ADDR_WIDTH-1:0] target;
    logic                     mispred;
    logic [IF_ADDR_WIDTH-1:0] next_pc;
  } branch_res_t;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - picks the next fetch PC from BTB/predictor lookup results
module next_pc_sel
  import if_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STEP       = INSTR_BYTES
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  btb_hit,
  input  logic [ADDR_WIDTH-1:0] btb_target,
  input  logic                  bp_hit,
  input  logic                  bp_pred,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  pred_taken
);

  // A taken prediction needs both structures to agree; sequential path wraps.
  assign pred_taken = btb_hit & bp_hit & bp_pred;
  assign next_pc    = pred_taken ? btb_target : pc + ADDR_WIDTH'(STEP);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - IF-stage sequencer: owns PC, one-outstanding imem fetch, redirects
module fetch_seq_ctrl
  import if_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    INSTR_BYTES = if_pkg::INSTR_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [ADDR_WIDTH-1:0]  lkp_pc_o,
  input  logic                   btb_hit_i,
  input  logic [ADDR_WIDTH-1:0]  btb_target_i,
  input  logic                   bp_hit_i,
  input  logic                   bp_pred_i,
  input  logic                   stall_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  output logic                   pred_taken_o,
  input  logic                   res_valid_i,
  input  logic [ADDR_WIDTH-1:0]  res_pc_i,
  input  logic                   res_taken_i,
  input  logic [ADDR_WIDTH-1:0]  res_target_i,
  input  logic                   res_mispred_i,
  input  logic [ADDR_WIDTH-1:0]  res_next_pc_i,
  output logic                   upd_en_o,
  output logic [ADDR_WIDTH-1:0]  upd_pc_o,
  output logic                   upd_taken_o,
  output logic [ADDR_WIDTH-1:0]  upd_target_o,
  output logic                   btb_upd_en_o
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  fetch_pred_q, fetch_pred_d;
  logic                  squash_q, squash_d;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  pred_taken;
  logic                  redirect;
  logic                  land;

  assign redirect    = res_valid_i & res_mispred_i;
  assign imem_addr_o = pc_q;
  assign lkp_pc_o    = pc_q;

  next_pc_sel #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (INSTR_BYTES)
  ) u_next_pc_sel (
    .pc         (pc_q),
    .btb_hit    (btb_hit_i),
    .btb_target (btb_target_i),
    .bp_hit     (bp_hit_i),
    .bp_pred    (bp_pred_i),
    .next_pc    (next_pc),
    .pred_taken (pred_taken)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_pred_d = fetch_pred_q;
    squash_d     = squash_q;
    land         = 1'b0;
    imem_req_o   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          state_d      = S_WAIT;
          fetch_pc_d   = pc_q;
          fetch_pred_d = pred_taken;
          pc_d         = next_pc;
          squash_d     = redirect;
        end else if (redirect) begin
          // Ungranted request is withdrawn for a cycle before re-requesting.
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          squash_d = 1'b0;
          state_d  = S_REQ;
          if (!squash_q && !redirect) begin
            land = 1'b1;
            if (stall_i) state_d = S_HOLD;
          end
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end
      S_HOLD: if (!stall_i || redirect) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    if (redirect) pc_d = res_next_pc_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      fetch_pred_q  <= 1'b0;
      squash_q      <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      pred_taken_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      fetch_pred_q <= fetch_pred_d;
      squash_q     <= squash_d;
      if (redirect)                          instr_valid_o <= 1'b0;
      else if (land)                         instr_valid_o <= 1'b1;
      else if (instr_valid_o && !stall_i)    instr_valid_o <= 1'b0;
      if (land) begin
        instr_o      <= imem_rdata_i;
        instr_pc_o   <= fetch_pc_q;
        pred_taken_o <= fetch_pred_q;
      end
    end
  end

  // Update path is a plain one-cycle copy of execute's resolution, independent of fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_en_o     <= 1'b0;
      upd_pc_o     <= '0;
      upd_taken_o  <= 1'b0;
      upd_target_o <= '0;
      btb_upd_en_o <= 1'b0;
    end else begin
      upd_en_o     <= res_valid_i;
      upd_pc_o     <= res_pc_i;
      upd_taken_o  <= res_taken_i;
      upd_target_o <= res_target_i;
      btb_upd_en_o <= res_valid_i & res_taken_i;
    end
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Instruction-fetch sequencer for the IF stage. It owns the PC and issues one-outstanding request/grant/response transactions to instruction memory. Each PC is looked up in branch_predictor and btb_mem to choose the next fetch address. It forwards resolved-branch updates from execute into both structures and applies execute redirects, squashing wrong-path responses.

Parameters:
ADDR_WIDTH, 32, PC/address width
INSTR_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset
INSTR_BYTES, 4, sequential PC increment

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset; synchronous, active-high
imem_req_o  out  1  fetch request, held until grant
imem_addr_o  out  ADDR_WIDTH  fetch address, stable while req high
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid (>=1 cycle after gnt)
imem_rdata_i  in  INSTR_WIDTH  response instruction
lkp_pc_o  out  ADDR_WIDTH  lookup address to predictor/BTB (= imem_addr_o)
btb_hit_i  in  1  BTB hit for lkp_pc_o
btb_target_i  in  ADDR_WIDTH  BTB target
bp_hit_i  in  1  predictor hit for lkp_pc_o
bp_pred_i  in  1  predictor says taken
stall_i  in  1  decode cannot accept instruction
instr_valid_o  out  1  instruction available to decode
instr_o  out  INSTR_WIDTH  fetched instruction
instr_pc_o  out  ADDR_WIDTH  PC of instr_o
pred_taken_o  out  1  prediction used for instr_o
res_valid_i  in  1  execute resolved a branch this cycle
res_pc_i  in  ADDR_WIDTH  branch PC
res_taken_i  in  1  actual outcome
res_target_i  in  ADDR_WIDTH  actual target
res_mispred_i  in  1  redirect required
res_next_pc_i  in  ADDR_WIDTH  correct next PC on mispredict
upd_en_o  out  1  write enable to predictor and BTB
upd_pc_o  out  ADDR_WIDTH  update address
upd_taken_o  out  1  update outcome
upd_target_o  out  ADDR_WIDTH  BTB data (written only if taken)
btb_upd_en_o  out  1  upd_en_o & upd_taken_o

Behaviour:
- Reset values: imem_req_o=0, pc_q=RESET_PC, instr_valid_o=0, pred_taken_o=0, upd_en_o=0, btb_upd_en_o=0, squash_q=0, state=S_IDLE.
- States:
  - S_IDLE: one cycle after reset, then S_REQ.
  - S_REQ: imem_req_o=1, addr=pc_q. On gnt, go to S_WAIT and capture pc_q, next_pc and pred_taken.
  - S_WAIT: on rvalid, if !squash_q load output regs and go to S_HOLD if stall_i else S_REQ; if squash_q, drop the data and go to S_REQ.
  - S_HOLD: outputs held stable; leave for S_REQ when stall_i=0.
- next_pc: btb_hit_i & bp_hit_i & bp_pred_i ? btb_target_i : pc_q+INSTR_BYTES. Addition wraps modulo 2^ADDR_WIDTH. Computed combinationally in S_REQ; pc_q updated on grant.
- instr_valid_o: registered. Set when an unsquashed response lands; cleared on the cycle it is consumed (valid & !stall_i) unless a new response lands the same cycle.
- Redirect (res_valid_i & res_mispred_i) has highest priority, any state:
  - pc_q <= res_next_pc_i; instr_valid_o <= 0.
  - In S_WAIT, or S_REQ with gnt the same cycle: squash_q <= 1 and the outstanding response is dropped when it arrives.
  - Response arriving the same cycle as a redirect is dropped.
  - S_REQ without gnt: imem_req_o deasserts next cycle, then re-requests res_next_pc_i.
  - S_HOLD: go to S_REQ.
- squash_q clears when the dropped response arrives.
- Update path: all update outputs are registered copies of res_*, so upd_en_o pulses exactly one cycle after each res_valid_i, independent of fetch state and stalls. Storage writes on negedge; a lookup in the cycle after upd_en_o sees the new value.
- Back-to-back res_valid_i produces back-to-back upd_en_o pulses.
- Only one memory transaction outstanding; imem_req_o is never high in S_WAIT or S_HOLD.
- Reset asserted mid-transaction returns to the reset values next cycle. A late rvalid after reset is ignored (S_IDLE/S_REQ do not sample rvalid).

Decomposition:
- Package if_pkg: fetch_state_e {S_IDLE,S_REQ,S_WAIT,S_HOLD}; INSTR_BYTES; typedef struct branch_res_t {pc, taken, target, mispred, next_pc} shared with execute.
- One combinational sub-module, next_pc_sel: hit/pred/target/pc in, next_pc and pred_taken out. Reusable when the predictor becomes set-associative.

Test Plan:
- Reset, memory with gnt same cycle and rvalid one cycle later, no hits -> imem_addr_o sequence 0x0, 0x4, 0x8; instr_pc_o matches each; pred_taken_o=0.
- lkp_pc=0x8 with btb_hit=1, bp_hit=1, bp_pred=1, target 0x40 -> next request 0x40, pred_taken_o=1 for 0x8. Same with bp_pred=0 -> 0xC.
- stall_i high 3 cycles while instr_valid_o=1 -> instr_o/instr_pc_o unchanged, no imem_req_o; resumes next address after release.
- Redirect to 0x100 while in S_WAIT for 0x10 -> 0x10 response dropped (instr_valid_o stays 0), next request is 0x100.
- res_valid_i two consecutive cycles (pc 0x20 taken target 0x80, pc 0x24 not-taken) -> upd_en_o pulses next two cycles with matching fields; btb_upd_en_o only for 0x20.
- rst asserted during S_WAIT, rvalid arrives the next cycle -> no instr_valid_o; first request after S_IDLE is RESET_PC.
